// File: rtl/comm_pkg.sv
// -----------------------------------------------------------------------------
// comm_pkg
// Shared definitions for the perceptron host protocol engine:
//   - opcode and response byte values
//   - FSM state encoding (shared by the top controller and the TX sequencer)
//   - transmit sequence kinds
//   - byte_lsb(): bit position of the idx-th byte of a packed word array
// -----------------------------------------------------------------------------
package comm_pkg;

  localparam logic [7:0] OP_READ       = 8'd5;
  localparam logic [7:0] OP_WR_WEIGHTS = 8'd50;
  localparam logic [7:0] OP_WR_INPUTS  = 8'd51;

  localparam logic [7:0] RESP_DATA     = 8'd100;
  localparam logic [7:0] RESP_OK       = 8'd101;
  localparam logic [7:0] RESP_ERR      = 8'd102;

  typedef enum logic [3:0] {
    IDLE,
    RX_WAIT,
    RX_STORE,
    RX_CHECK,
    COMMIT,
    TX_LOAD,
    TX_SEND,
    TX_GUARD,
    TX_WAIT
  } state_t;

  typedef enum logic [1:0] {
    TXK_READ,
    TXK_OK,
    TXK_ERR
  } tx_kind_t;

  // Bytes travel word 0 first and MSB first within a word, while word i sits
  // at [i*W +: W]. Maps a wire-order byte index onto its LSB bit position.
  function automatic int byte_lsb(input int idx, input int wb);
    return ((idx / wb) * wb + (wb - 1 - (idx % wb))) * 8;
  endfunction

  function automatic logic is_write_op(input logic [7:0] b);
    return (b == OP_WR_WEIGHTS) || (b == OP_WR_INPUTS);
  endfunction

endpackage

// File: rtl/comm_tx_sequencer.sv
// -----------------------------------------------------------------------------
// comm_tx_sequencer
// Hands one byte to the UART transmitter with a busy-aware handshake:
//   TX_SEND  : wait for tx_busy low, then pulse tx_send for one cycle
//   TX_GUARD : one cycle that ignores tx_busy (the UART needs a cycle to raise it)
//   TX_WAIT  : wait for tx_busy low, then pulse done and return to IDLE
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   tx_busy      UART transmitter busy
//   byte_in      byte to send, captured when start is high in IDLE
//   start        one-cycle request to send byte_in
//   done         one-cycle pulse when the UART has finished with the byte
//   tx_byte      byte to the UART, forced to 0 whenever tx_send is low
//   tx_send      one-cycle pulse starting a UART transmission
// -----------------------------------------------------------------------------
module comm_tx_sequencer
  import comm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_busy,
  input  logic [7:0] byte_in,
  input  logic       start,
  output logic       done,
  output logic [7:0] tx_byte,
  output logic       tx_send
);

  state_t     state_q, state_d;
  logic [7:0] byte_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) byte_q <= byte_in;
    end
  end

  // NOTE: every combinational output gets a default first so no path
  // through the case infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start)    state_d = TX_SEND;
      TX_SEND:  if (!tx_busy) state_d = TX_GUARD;
      TX_GUARD:               state_d = TX_WAIT;
      TX_WAIT:  if (!tx_busy) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_send = (state_q == TX_SEND) && !tx_busy;
    tx_byte = tx_send ? byte_q : 8'h00;
    done    = (state_q == TX_WAIT) && !tx_busy;
  end

endmodule

// File: rtl/comm_controller_n.sv
// -----------------------------------------------------------------------------
// comm_controller_n
// Byte-level host protocol engine between the UART rx/tx pair and an
// N-input perceptron core.
//   Write frame : opcode, N_INPUTS*WORD_BYTES payload bytes, XOR checksum
//                 -> RESP_OK and a one-cycle commit strobe, or RESP_ERR
//   Read        : READ -> RESP_DATA, weight words, result word, XOR checksum
//   Errors      : bad checksum, unknown opcode or inter-byte timeout send
//                 RESP_ERR and set the sticky frame_err flag
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rx_byte, rx_ready   received byte, valid while rx_ready is high
//   rx_clear            one-cycle pulse consuming rx_byte
//   tx_busy             UART transmitter busy
//   tx_byte, tx_send    byte to transmit and its one-cycle start pulse
//   weights, result     live perceptron weights and output (read source)
//   weights_new         committed weights, word i at [i*W +: W]
//   inputs_new          committed inputs, same packing
//   weight_write        one-cycle strobe, weights_new updated this cycle
//   input_write         one-cycle strobe, inputs_new updated this cycle
//   frame_err           sticky error flag, cleared by the next good frame
// -----------------------------------------------------------------------------
module comm_controller_n
  import comm_pkg::*;
#(
  parameter int N_INPUTS       = 2,
  parameter int WORD_BYTES     = 2,
  parameter int TIMEOUT_CYCLES = 120000
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [7:0]                        rx_byte,
  input  logic                              rx_ready,
  input  logic                              tx_busy,
  input  logic [N_INPUTS*8*WORD_BYTES-1:0]  weights,
  input  logic [8*WORD_BYTES-1:0]           result,
  output logic                              rx_clear,
  output logic [7:0]                        tx_byte,
  output logic                              tx_send,
  output logic [N_INPUTS*8*WORD_BYTES-1:0]  weights_new,
  output logic [N_INPUTS*8*WORD_BYTES-1:0]  inputs_new,
  output logic                              weight_write,
  output logic                              input_write,
  output logic                              frame_err
);

  localparam int W      = 8 * WORD_BYTES;
  localparam int P      = N_INPUTS * WORD_BYTES;        // payload bytes
  localparam int TX_LEN = P + WORD_BYTES + 2;           // full read reply
  localparam int CW     = $clog2(P + 1);
  localparam int IW     = $clog2(TX_LEN);
  localparam int TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t                  state_q, state_d;
  tx_kind_t                tx_kind_q;
  logic [7:0]              op_q;
  logic [CW-1:0]           cnt_q;
  logic [7:0]              chk_q;
  logic [N_INPUTS*W-1:0]   shadow_q;
  logic [TW-1:0]           timer_q;
  logic [IW-1:0]           tx_idx_q;
  logic [7:0]              tx_chk_q;
  logic                    alive_q;

  logic                    rx_take;
  logic                    timer_fire;
  logic                    tx_last;
  logic [7:0]              load_byte;
  logic                    seq_start;
  logic                    seq_done;

  // alive_q is 0 only while reset is held and on the first edge after it,
  // keeping rx_clear low in reset even if the UART is already presenting a byte.
  assign rx_take    = rx_ready && alive_q;
  assign timer_fire = (timer_q == TW'(TIMEOUT_CYCLES - 1));
  assign tx_last    = (tx_kind_q != TXK_READ) || (int'(tx_idx_q) == TX_LEN - 1);

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rx_take) state_d = is_write_op(rx_byte) ? RX_WAIT : TX_LOAD;
      end
      RX_WAIT: begin
        if (rx_ready)        state_d = (cnt_q != '0) ? RX_STORE : RX_CHECK;
        else if (timer_fire) state_d = TX_LOAD;
      end
      RX_STORE: state_d = RX_WAIT;
      RX_CHECK: state_d = (rx_byte == chk_q) ? COMMIT : TX_LOAD;
      COMMIT:   state_d = TX_LOAD;
      TX_LOAD:  state_d = TX_SEND;
      // The top parks in TX_SEND while the sequencer walks its own
      // TX_SEND / TX_GUARD / TX_WAIT handshake for the current byte.
      TX_SEND: begin
        if (seq_done) state_d = tx_last ? IDLE : TX_LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    rx_clear  = 1'b0;
    seq_start = 1'b0;
    case (state_q)
      IDLE:               rx_clear  = rx_take;
      RX_STORE, RX_CHECK: rx_clear  = 1'b1;
      TX_LOAD:            seq_start = 1'b1;
      default: ;
    endcase
  end

  // Byte for the current reply position. Read data is sampled here, one byte
  // at a time, so a reply is not an atomic snapshot of the weights.
  always_comb begin
    load_byte = RESP_ERR;
    case (tx_kind_q)
      TXK_OK:  load_byte = RESP_OK;
      TXK_ERR: load_byte = RESP_ERR;
      default: begin
        if (tx_idx_q == '0) begin
          load_byte = RESP_DATA;
        end else if (int'(tx_idx_q) == TX_LEN - 1) begin
          load_byte = tx_chk_q;
        end else begin
          load_byte = 8'h00;
          for (int b = 0; b < P; b++)
            if (int'(tx_idx_q) == b + 1)
              load_byte = weights[byte_lsb(b, WORD_BYTES) +: 8];
          for (int b = 0; b < WORD_BYTES; b++)
            if (int'(tx_idx_q) == P + 1 + b)
              load_byte = result[byte_lsb(b, WORD_BYTES) +: 8];
        end
      end
    endcase
  end

  // ----------------------------------------------------------------- datapath
  // NOTE: the shadow buffer is a plain register vector, not a RAM, so it is
  // cleared by reset like every other flop here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_kind_q    <= TXK_OK;
      op_q         <= '0;
      cnt_q        <= '0;
      chk_q        <= '0;
      shadow_q     <= '0;
      timer_q      <= '0;
      tx_idx_q     <= '0;
      tx_chk_q     <= '0;
      alive_q      <= 1'b0;
      weights_new  <= '0;
      inputs_new   <= '0;
      weight_write <= 1'b0;
      input_write  <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      alive_q      <= 1'b1;
      weight_write <= 1'b0;
      input_write  <= 1'b0;

      case (state_q)
        IDLE: begin
          tx_idx_q <= '0;
          tx_chk_q <= '0;
          if (rx_take) begin
            timer_q <= '0;
            if (is_write_op(rx_byte)) begin
              op_q  <= rx_byte;
              cnt_q <= CW'(P);
              chk_q <= rx_byte;
            end else if (rx_byte == OP_READ) begin
              tx_kind_q <= TXK_READ;
            end else begin
              tx_kind_q <= TXK_ERR;
              frame_err <= 1'b1;
            end
          end
        end

        RX_WAIT: begin
          if (!rx_ready) begin
            if (timer_fire) begin
              timer_q   <= '0;
              tx_kind_q <= TXK_ERR;
              frame_err <= 1'b1;
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end
        end

        RX_STORE: begin
          for (int b = 0; b < P; b++)
            if (b == P - int'(cnt_q))
              shadow_q[byte_lsb(b, WORD_BYTES) +: 8] <= rx_byte;
          chk_q   <= chk_q ^ rx_byte;
          cnt_q   <= cnt_q - CW'(1);
          timer_q <= '0;
        end

        RX_CHECK: begin
          timer_q <= '0;
          if (rx_byte != chk_q) begin
            tx_kind_q <= TXK_ERR;
            frame_err <= 1'b1;
          end
        end

        // Committed words and their strobe change on the same edge, so the
        // core never sees a half-written word.
        COMMIT: begin
          if (op_q == OP_WR_WEIGHTS) begin
            weights_new  <= shadow_q;
            weight_write <= 1'b1;
          end else begin
            inputs_new  <= shadow_q;
            input_write <= 1'b1;
          end
          frame_err <= 1'b0;
          tx_kind_q <= TXK_OK;
        end

        TX_LOAD: tx_chk_q <= tx_chk_q ^ load_byte;

        TX_SEND: begin
          if (seq_done && !tx_last) tx_idx_q <= tx_idx_q + IW'(1);
        end

        default: ;
      endcase
    end
  end

  comm_tx_sequencer u_tx_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_busy (tx_busy),
    .byte_in (load_byte),
    .start   (seq_start),
    .done    (seq_done),
    .tx_byte (tx_byte),
    .tx_send (tx_send)
  );

endmodule

// File: tb/tb_comm_controller_n.sv
// -----------------------------------------------------------------------------
// tb_comm_controller_n
// Directed bench for comm_controller_n (N_INPUTS=2, WORD_BYTES=2, short
// timeout). A small host model feeds rx bytes and honours rx_clear; a UART tx
// model logs every transmitted byte and holds tx_busy for busy_len cycles.
// -----------------------------------------------------------------------------
module tb_comm_controller_n;

  localparam int NI = 2;
  localparam int WB = 2;
  localparam int TO = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0]        rx_byte;
  logic              rx_ready;
  logic              tx_busy = 1'b0;
  logic [NI*8*WB-1:0] weights;
  logic [8*WB-1:0]   result;
  logic              rx_clear;
  logic [7:0]        tx_byte;
  logic              tx_send;
  logic [NI*8*WB-1:0] weights_new;
  logic [NI*8*WB-1:0] inputs_new;
  logic              weight_write;
  logic              input_write;
  logic              frame_err;

  int n_cmp = 0;
  int n_bad = 0;

  // monitor state
  logic       snap_send = 1'b0;
  logic [7:0] snap_byte = 8'h00;
  logic       snap_busy = 1'b0;
  logic [7:0] tx_log [0:255];
  int         tx_cnt = 0;
  int         busy_viol = 0;
  int         idle_byte_viol = 0;
  int         busy_left = 0;
  int         busy_len = 3;
  int         clr_cnt = 0;
  int         ww_cnt = 0;
  int         iw_cnt = 0;

  logic [7:0] exp_rd  [0:7] = '{8'h64, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF, 8'hDB};
  logic [7:0] exp_rd2 [0:7] = '{8'h64, 8'hF0, 8'h0F, 8'h01, 8'h02, 8'h80, 8'h01, 8'h19};

  comm_controller_n #(
    .N_INPUTS       (NI),
    .WORD_BYTES     (WB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_byte      (rx_byte),
    .rx_ready     (rx_ready),
    .tx_busy      (tx_busy),
    .weights      (weights),
    .result       (result),
    .rx_clear     (rx_clear),
    .tx_byte      (tx_byte),
    .tx_send      (tx_send),
    .weights_new  (weights_new),
    .inputs_new   (inputs_new),
    .weight_write (weight_write),
    .input_write  (input_write),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  // Sample DUT outputs mid-cycle.
  always @(negedge clk) begin
    snap_send = tx_send;
    snap_byte = tx_byte;
    snap_busy = tx_busy;
    if (!tx_send && tx_byte != 8'h00) idle_byte_viol++;
    if (rx_clear)     clr_cnt++;
    if (weight_write) ww_cnt++;
    if (input_write)  iw_cnt++;
  end

  // UART transmitter model: accepts the byte at the edge, then reports busy.
  always @(posedge clk) begin
    #1;
    if (snap_send) begin
      tx_log[tx_cnt & 255] = snap_byte;
      tx_cnt++;
      if (snap_busy) busy_viol++;
      busy_left = busy_len;
    end else if (busy_left > 0) begin
      busy_left--;
    end
    tx_busy = (busy_left > 0);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one byte and hold it until the DUT pulses rx_clear.
  task automatic send_byte(input logic [7:0] b);
    logic got;
    got = 1'b0;
    @(negedge clk);
    rx_byte  = b;
    rx_ready = 1'b1;
    for (int i = 0; i < 4000 && !got; i++) begin
      #1;
      if (rx_clear) got = 1'b1;
      else @(negedge clk);
    end
    if (got) begin
      @(posedge clk);
      #1;
    end
    rx_ready = 1'b0;
    check("rx_accept", got, 1'b1);
  endtask

  task automatic send6(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
    send_byte(b4);
    send_byte(b5);
  endtask

  task automatic wait_tx(input int target, input int budget, input string tag);
    int i;
    i = 0;
    while (tx_cnt < target && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(tag, (tx_cnt >= target), 1'b1);
  endtask

  int base, ww0, iw0, clr0, bv0;

  initial begin
    rst_n    = 1'b0;
    rx_byte  = 8'h05;
    rx_ready = 1'b1;
    weights  = '0;
    result   = '0;

    // ---- reset: outputs held at 0 even with a byte waiting
    repeat (3) @(negedge clk);
    #1;
    check("rst rx_clear", rx_clear, 1'b0);
    check("rst tx_send", tx_send, 1'b0);
    check("rst tx_byte", tx_byte, 8'h00);
    check("rst weights_new", weights_new, 32'h0);
    check("rst inputs_new", inputs_new, 32'h0);
    check("rst strobes", {weight_write, input_write}, 2'b00);
    check("rst frame_err", frame_err, 1'b0);
    rx_ready = 1'b0;
    rx_byte  = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post-rst quiet", tx_cnt, 0);

    // ---- good weight write
    base = tx_cnt; ww0 = ww_cnt; iw0 = iw_cnt;
    send6(8'h32, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h72);
    wait_tx(base + 1, 500, "wr tx wait");
    check("wr resp", tx_log[base & 255], 8'h65);
    check("wr weights_new", weights_new, 32'hABCD1234);
    check("wr strobe cycles", ww_cnt - ww0, 1);
    check("wr no input strobe", iw_cnt - iw0, 0);
    check("wr frame_err", frame_err, 1'b0);

    // ---- timeout after one payload byte; fires on the exact cycle
    base = tx_cnt; iw0 = iw_cnt;
    repeat (10) @(negedge clk);
    send_byte(8'h33);
    send_byte(8'h01);
    repeat (TO + 1) @(negedge clk);
    #1;
    check("to not early", tx_send, 1'b0);
    @(negedge clk);
    #1;
    check("to fire send", tx_send, 1'b1);
    check("to fire byte", tx_byte, 8'h66);
    wait_tx(base + 1, 200, "to tx wait");
    check("to resp", tx_log[base & 255], 8'h66);
    check("to frame_err", frame_err, 1'b1);
    check("to no strobe", iw_cnt - iw0, 0);
    check("to inputs_new", inputs_new, 32'h0);

    // ---- good input frame clears frame_err
    base = tx_cnt; ww0 = ww_cnt; iw0 = iw_cnt;
    send6(8'h33, 8'h00, 8'h05, 8'hFF, 8'hFE, 8'h37);
    wait_tx(base + 1, 500, "in tx wait");
    check("in resp", tx_log[base & 255], 8'h65);
    check("in inputs_new", inputs_new, 32'hFFFE0005);
    check("in strobe cycles", iw_cnt - iw0, 1);
    check("in no weight strobe", ww_cnt - ww0, 0);
    check("in weights kept", weights_new, 32'hABCD1234);
    check("in frame_err", frame_err, 1'b0);

    // ---- unknown opcode
    base = tx_cnt; clr0 = clr_cnt;
    send_byte(8'h07);
    wait_tx(base + 1, 500, "unk tx wait");
    repeat (30) @(negedge clk);
    check("unk tx count", tx_cnt - base, 1);
    check("unk resp", tx_log[base & 255], 8'h66);
    check("unk rx_clear count", clr_cnt - clr0, 1);
    check("unk frame_err", frame_err, 1'b1);

    // ---- second good weight write, then a bad-checksum frame
    base = tx_cnt;
    send6(8'h32, 8'h00, 8'h01, 8'h80, 8'h00, 8'hB3);
    wait_tx(base + 1, 500, "wr2 tx wait");
    check("wr2 resp", tx_log[base & 255], 8'h65);
    check("wr2 weights_new", weights_new, 32'h80000001);
    check("wr2 frame_err", frame_err, 1'b0);

    base = tx_cnt; ww0 = ww_cnt;
    send6(8'h32, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h73);
    wait_tx(base + 1, 500, "bad tx wait");
    check("bad resp", tx_log[base & 255], 8'h66);
    check("bad no strobe", ww_cnt - ww0, 0);
    check("bad weights kept", weights_new, 32'h80000001);
    check("bad frame_err", frame_err, 1'b1);

    // ---- read with a slow transmitter
    weights  = {16'hABCD, 16'h1234};
    result   = 16'h00FF;
    busy_len = 50;
    base = tx_cnt; bv0 = busy_viol;
    repeat (60) @(negedge clk);
    send_byte(8'h05);
    wait_tx(base + 8, 2000, "rd tx wait");
    repeat (80) @(negedge clk);
    check("rd tx count", tx_cnt - base, 8);
    for (int i = 0; i < 8; i++)
      check($sformatf("rd byte%0d", i), tx_log[(base + i) & 255], exp_rd[i]);
    check("rd never while busy", busy_viol - bv0, 0);
    check("rd frame_err held", frame_err, 1'b1);

    // ---- read with different data and a fast transmitter
    weights  = {16'h0102, 16'hF00F};
    result   = 16'h8001;
    busy_len = 3;
    base = tx_cnt;
    send_byte(8'h05);
    wait_tx(base + 8, 500, "rd2 tx wait");
    for (int i = 0; i < 8; i++)
      check($sformatf("rd2 byte%0d", i), tx_log[(base + i) & 255], exp_rd2[i]);

    // ---- reset asserted mid-read
    busy_len = 50;
    base = tx_cnt;
    repeat (20) @(negedge clk);
    send_byte(8'h05);
    wait_tx(base + 3, 1000, "mr tx wait");
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr tx_send", tx_send, 1'b0);
    check("mr tx_byte", tx_byte, 8'h00);
    check("mr rx_clear", rx_clear, 1'b0);
    check("mr strobes", {weight_write, input_write}, 2'b00);
    check("mr weights_new", weights_new, 32'h0);
    check("mr inputs_new", inputs_new, 32'h0);
    check("mr frame_err", frame_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    base = tx_cnt;
    repeat (300) @(negedge clk);
    check("mr no tx after release", tx_cnt - base, 0);
    busy_len = 3;
    send_byte(8'h07);
    wait_tx(base + 1, 500, "mr new op tx wait");
    check("mr new op resp", tx_log[base & 255], 8'h66);

    check("tx_byte zero when idle", idle_byte_viol, 0);
    check("no tx_send while busy", busy_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
